cdc_chan_arbiter: RTL and testbench
===================================

CDC_CHAN_ARBITER -- requirements
Module: cdc_chan_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the crossing channel.
REQ-002 Parameter DW, default 8: channel data width.
REQ-003 Parameter TO_CYC, default 64: handshake timeout in slow_clk cycles.
REQ-004 slow_clk  in  1  sole clock; all state on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_i  in  NREQ  per-requester request level, held until done_o or err_o.
REQ-007 data_i  in  NREQ*DW  per-requester payload, slice i = bits [i*DW +: DW].
REQ-008 xfer_ack_i  in  1  channel acknowledge, already synchronized into slow_clk domain.
REQ-009 xfer_req_o  out  1  channel request level toward the fast domain.
REQ-010 xfer_data_o  out  DW  channel payload, registered.
REQ-011 done_o  out  NREQ  one-cycle pulse on bit of served requester.
REQ-012 err_o  out  NREQ  one-cycle pulse on bit of requester whose transfer timed out.
REQ-013 busy_o  out  1  high whenever FSM not in IDLE.
REQ-014 gnt_id_o  out  clog2(NREQ)  index of current/last granted requester.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, REQ, REL, DONE; all outputs registered.
REQ-016 IDLE: if any req_i bit set, SHALL select winner round-robin, latch its data_i slice into xfer_data_o, latch gnt_id_o, go SETUP; else stay.
REQ-017 Round-robin: after serving index i (done or error), highest priority SHALL move to (i+1) mod NREQ; priority pointer resets to 0.
REQ-018 SETUP: one cycle, xfer_data_o stable, xfer_req_o low; then REQ (data precedes request by one cycle).
REQ-019 REQ: xfer_req_o=1; on xfer_ack_i=1 go REL.
REQ-020 REL: xfer_req_o=0; on xfer_ack_i=0 go DONE, or IDLE if transaction flagged error.
REQ-021 DONE: done_o[gnt_id_o]=1 for exactly one cycle, then IDLE.
REQ-022 Latency: req_i sampled in IDLE at cycle 0 -> xfer_req_o high at cycle 2; ack low sampled at cycle m -> done_o at cycle m+1.
REQ-023 xfer_data_o SHALL be unchanged from SETUP until next IDLE->SETUP transition.
REQ-024 Timeout counter SHALL clear on entry to REQ and to REL, count each cycle in those states, saturate.
REQ-025 Counter reaching TO_CYC in REQ: err_o[gnt] pulse, set error flag, go REL.
REQ-026 Counter reaching TO_CYC in REL: err_o[gnt] pulse unless already pulsed this transaction, go IDLE; done_o never pulses for an errored transaction.
REQ-027 Deassertion of req_i mid-transaction SHALL NOT abort the transfer; new requests wait for IDLE.
REQ-028 A req_i still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-029 Requests from all NREQ bits simultaneously SHALL be served in rotating order, none starved.

Reset
REQ-030 On reset_n low, asynchronously: state IDLE, xfer_req_o=0, xfer_data_o=0, done_o=0, err_o=0, busy_o=0, gnt_id_o=0, pointer=0, counter=0, error flag=0.
REQ-031 Reset mid-transaction SHALL drop xfer_req_o immediately; no done_o/err_o for the aborted transfer.

Structure
REQ-032 FSM state encoding and default NREQ/DW/TO_CYC constants SHALL live in shared package cdc_pkg.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector, pointer; output one-hot grant and index), combinational.

Verification
REQ-034 Single request: req_i=4'b0100, data_i slice 2=8'hA5, ack rises 3 cycles after xfer_req_o, falls 3 cycles after its drop -> xfer_data_o=8'hA5 one cycle before xfer_req_o, done_o=4'b0100 once, gnt_id_o=2.
REQ-035 All four requesting from reset -> service order 0,1,2,3; second round after new requests 0 and 3 -> order 0,3.
REQ-036 Ack never rises, TO_CYC=64 -> err_o[gnt] pulse 64 cycles after xfer_req_o high, xfer_req_o drops, no done_o, FSM returns IDLE once ack low.
REQ-037 Ack stuck high after drop -> single err_o pulse at TO_CYC in REL, IDLE afterwards, next requester served normally.
REQ-038 reset_n pulsed low while in REQ -> xfer_req_o=0 immediately, all outputs at reset values, pending requests restart from pointer 0.
REQ-039 Requester 1 drops req_i during REQ -> transfer completes, done_o[1] pulses, data unchanged throughout.

Source files
------------

// File: rtl/cdc_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
// Shared definitions for the CDC channel arbiter slice: FSM state encoding,
// default sizing constants and a helper for index widths.
// ---------------------------------------------------------------------------
package cdc_pkg;

  // Handshake FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_REQ   = 3'd2,
    ST_REL   = 3'd3,
    ST_DONE  = 3'd4
  } cdc_state_e;

  localparam int CDC_NREQ   = 4;
  localparam int CDC_DW     = 8;
  localparam int CDC_TO_CYC = 64;

  // Width of an index into n items; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Scans the request vector starting at
// the priority pointer and wrapping around; the first set bit wins.
//
// Ports
//   req        in   NREQ  request vector
//   ptr        in   GW    index holding highest priority
//   gnt        out  NREQ  one-hot grant (all zero when no request)
//   gnt_idx    out  GW    index of the granted requester
//   gnt_valid  out  1     at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
  import cdc_pkg::*;
#(
  parameter int NREQ = CDC_NREQ
) (
  input  logic [NREQ-1:0]            req,
  input  logic [idx_width(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]            gnt,
  output logic [idx_width(NREQ)-1:0] gnt_idx,
  output logic                       gnt_valid
);

  localparam int GW = idx_width(NREQ);

  logic [GW-1:0] cand_s;
  logic          hit_s;
  logic          found_s;

  // Index that lies off positions after base, modulo NREQ
  function automatic logic [GW-1:0] rot_idx(input logic [GW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= NREQ) ? (sum - NREQ) : sum;
    return sum[GW-1:0];
  endfunction

  // Priority scan from ptr; only the first hit is granted
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s       = rot_idx(ptr, k);
      hit_s        = !found_s && req[cand_s];
      gnt[cand_s]  = gnt[cand_s] | hit_s;
      gnt_idx      = hit_s ? cand_s : gnt_idx;
      found_s      = found_s | hit_s;
    end
    gnt_valid = found_s;
  end

endmodule

// File: rtl/cdc_chan_arbiter.sv
// ---------------------------------------------------------------------------
// cdc_chan_arbiter
// Shares one four-phase request/acknowledge crossing channel among NREQ
// requesters. A round-robin winner is picked in IDLE, its payload is latched
// one cycle ahead of the channel request, and the handshake is supervised by
// a timeout in both the request and release phases.
//
// Ports
//   slow_clk     in   1        sole clock, rising edge
//   reset_n      in   1        asynchronous active-low reset
//   req_i        in   NREQ     request levels, held until done_o/err_o
//   data_i       in   NREQ*DW  payloads, slice i = [i*DW +: DW]
//   xfer_ack_i   in   1        channel acknowledge (already synchronized)
//   xfer_req_o   out  1        channel request level
//   xfer_data_o  out  DW       channel payload
//   done_o       out  NREQ     one-cycle completion pulse
//   err_o        out  NREQ     one-cycle timeout pulse
//   busy_o       out  1        FSM outside IDLE
//   gnt_id_o     out  GW       current/last granted requester
// ---------------------------------------------------------------------------
module cdc_chan_arbiter
  import cdc_pkg::*;
#(
  parameter int NREQ   = CDC_NREQ,
  parameter int DW     = CDC_DW,
  parameter int TO_CYC = CDC_TO_CYC
) (
  input  logic                       slow_clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ*DW-1:0]         data_i,
  input  logic                       xfer_ack_i,
  output logic                       xfer_req_o,
  output logic [DW-1:0]              xfer_data_o,
  output logic [NREQ-1:0]            done_o,
  output logic [NREQ-1:0]            err_o,
  output logic                       busy_o,
  output logic [idx_width(NREQ)-1:0] gnt_id_o
);

  localparam int GW = idx_width(NREQ);
  localparam int CW = $clog2(TO_CYC + 1);
  // The counter reads k during the (k+1)-th cycle of a phase, so this value
  // marks the TO_CYC-th cycle spent waiting.
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  cdc_state_e      state_r;
  logic [GW-1:0]   ptr_r;
  logic [CW-1:0]   cnt_r;
  logic            err_flag_r;

  logic [NREQ-1:0] win_gnt_s;
  logic [GW-1:0]   win_idx_s;
  logic            win_valid_s;
  logic [DW-1:0]   win_data_s;
  logic [NREQ-1:0] gnt_mask_s;
  logic [GW-1:0]   ptr_next_s;
  logic [CW-1:0]   cnt_inc_s;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req       (req_i),
    .ptr       (ptr_r),
    .gnt       (win_gnt_s),
    .gnt_idx   (win_idx_s),
    .gnt_valid (win_valid_s)
  );

  // Payload of the round-robin winner
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_data_s = win_data_s | ({DW{win_gnt_s[i]}} & data_i[i*DW +: DW]);
    end
  end

  // One-hot of the granted index, pointer successor and saturating count
  always_comb begin
    gnt_mask_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_mask_s[i] = (int'(gnt_id_o) == i);
    end
    ptr_next_s = (int'(gnt_id_o) == (NREQ - 1)) ? '0 : (gnt_id_o + GW'(1'b1));
    cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CW'(1'b1));
  end

  // Handshake FSM with all outputs registered
  always_ff @(posedge slow_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      cnt_r       <= '0;
      err_flag_r  <= 1'b0;
      xfer_req_o  <= 1'b0;
      xfer_data_o <= '0;
      done_o      <= '0;
      err_o       <= '0;
      busy_o      <= 1'b0;
      gnt_id_o    <= '0;
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (state_r)
        ST_IDLE: begin
          if (win_valid_s) begin
            state_r     <= ST_SETUP;
            xfer_data_o <= win_data_s;
            gnt_id_o    <= win_idx_s;
            err_flag_r  <= 1'b0;
            busy_o      <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end
        ST_SETUP: begin
          // Payload has been stable for a cycle; raise the request now
          state_r    <= ST_REQ;
          xfer_req_o <= 1'b1;
          cnt_r      <= '0;
        end
        ST_REQ: begin
          if (xfer_ack_i) begin
            state_r    <= ST_REL;
            xfer_req_o <= 1'b0;
            cnt_r      <= '0;
          end else if (cnt_r == TO_LAST) begin
            // No ack: report now, then still wait for a clean release
            err_o      <= gnt_mask_s;
            err_flag_r <= 1'b1;
            state_r    <= ST_REL;
            xfer_req_o <= 1'b0;
            cnt_r      <= '0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_REL: begin
          if (!xfer_ack_i) begin
            ptr_r <= ptr_next_s;
            if (err_flag_r) begin
              state_r <= ST_IDLE;
              busy_o  <= 1'b0;
            end else begin
              state_r <= ST_DONE;
              done_o  <= gnt_mask_s;
            end
          end else if (cnt_r == TO_LAST) begin
            // Ack stuck high; only one error pulse per transaction
            if (!err_flag_r) begin
              err_o <= gnt_mask_s;
            end else begin
              err_o <= '0;
            end
            err_flag_r <= 1'b1;
            ptr_r      <= ptr_next_s;
            state_r    <= ST_IDLE;
            busy_o     <= 1'b0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          xfer_req_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_chan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdc_chan_arbiter
// Scoreboard bench: each request set pushes its expected service records
// (requester, payload, done/error) from a round-robin reference model; a
// monitor pops and compares them whenever done_o or err_o pulses. A small
// acknowledge responder plays the fast-domain side of the channel.
// ---------------------------------------------------------------------------
module tb_cdc_chan_arbiter;

  localparam int NREQ   = 4;
  localparam int DW     = 8;
  localparam int TO_CYC = 64;

  logic              slow_clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_i;
  logic [NREQ*DW-1:0] data_i;
  logic              xfer_ack_i;
  logic              xfer_req_o;
  logic [DW-1:0]     xfer_data_o;
  logic [NREQ-1:0]   done_o;
  logic [NREQ-1:0]   err_o;
  logic              busy_o;
  logic [1:0]        gnt_id_o;

  cdc_chan_arbiter #(
    .NREQ   (NREQ),
    .DW     (DW),
    .TO_CYC (TO_CYC)
  ) dut (
    .slow_clk    (slow_clk),
    .reset_n     (reset_n),
    .req_i       (req_i),
    .data_i      (data_i),
    .xfer_ack_i  (xfer_ack_i),
    .xfer_req_o  (xfer_req_o),
    .xfer_data_o (xfer_data_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .gnt_id_o    (gnt_id_o)
  );

  initial begin
    slow_clk = 1'b0;
    forever #5 slow_clk = ~slow_clk;
  end

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         is_err;
  } exp_t;

  exp_t sb[$];

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   last_edge_cyc = 0;
  int   ack_fall_cyc  = 0;
  int   hi_cnt   = 0;
  int   lo_cnt   = 0;
  int   model_ptr = 0;
  int   ack_mode = 0;   // 0 normal, 1 never acknowledge, 2 ack sticks high
  int   hold_bad = 0;
  logic prev_xreq = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference round-robin: queue expected services for a request set
  task automatic push_service(input logic [3:0] reqs, input bit is_err);
    logic [3:0] pend;
    exp_t       e;
    int         id;
    pend = reqs;
    while (pend != 4'd0) begin
      id = model_ptr;
      while (!pend[id]) id = (id + 1) % NREQ;
      e.id     = id;
      e.data   = data_i[id*DW +: DW];
      e.is_err = is_err;
      sb.push_back(e);
      pend[id]  = 1'b0;
      model_ptr = (id + 1) % NREQ;
    end
  endtask

  // One cycle: monitor/scoreboard, xfer_req edge tracking, ack responder
  task automatic tick();
    exp_t e;
    @(negedge slow_clk);
    cyc++;
    if ((done_o | err_o) != 4'd0) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", 32'(done_o | err_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("gnt_id", 32'(gnt_id_o), 32'(e.id));
        check_eq("xfer_data", 32'(xfer_data_o), 32'(e.data));
        if (e.is_err) begin
          check_eq("err_vec", 32'(err_o), 32'(1 << e.id));
          check_eq("done_vec", 32'(done_o), 32'd0);
          check_eq("err_latency", 32'(cyc - last_edge_cyc), 32'(TO_CYC));
          check_eq("err_req_low", 32'(xfer_req_o), 32'd0);
        end else begin
          check_eq("done_vec", 32'(done_o), 32'(1 << e.id));
          check_eq("err_vec", 32'(err_o), 32'd0);
          check_eq("done_latency", 32'(cyc - ack_fall_cyc), 32'd1);
        end
      end
      req_i = req_i & ~(done_o | err_o);
    end
    if (xfer_req_o !== prev_xreq) last_edge_cyc = cyc;
    prev_xreq = xfer_req_o;
    if (xfer_req_o) begin
      lo_cnt = 0;
      if (ack_mode != 1 && !xfer_ack_i) begin
        hi_cnt++;
        if (hi_cnt >= 3) begin
          xfer_ack_i = 1'b1;
          hi_cnt = 0;
        end
      end
    end else begin
      hi_cnt = 0;
      if (xfer_ack_i && ack_mode != 2) begin
        lo_cnt++;
        if (lo_cnt >= 3) begin
          xfer_ack_i   = 1'b0;
          lo_cnt       = 0;
          ack_fall_cyc = cyc;
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o) && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_scoreboard", 32'(sb.size()), 32'd0);
    check_eq("drain_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    xfer_ack_i = 1'b0;
    hi_cnt     = 0;
    lo_cnt     = 0;
    sb.delete();
    model_ptr  = 0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string phase);
    check_eq({phase, "_xfer_req"},  32'(xfer_req_o),  32'd0);
    check_eq({phase, "_xfer_data"}, 32'(xfer_data_o), 32'd0);
    check_eq({phase, "_done"},      32'(done_o),      32'd0);
    check_eq({phase, "_err"},       32'(err_o),       32'd0);
    check_eq({phase, "_busy"},      32'(busy_o),      32'd0);
    check_eq({phase, "_gnt"},       32'(gnt_id_o),    32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_i      = 4'd0;
    data_i     = 32'd0;
    xfer_ack_i = 1'b0;

    // Reset state
    tick();
    check_reset_outputs("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // Single request with data-before-request timing
    data_i = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    req_i  = 4'b0100;
    push_service(req_i, 1'b0);
    tick();
    check_eq("setup_data", 32'(xfer_data_o), 32'hA5);
    check_eq("setup_req_low", 32'(xfer_req_o), 32'd0);
    check_eq("setup_gnt", 32'(gnt_id_o), 32'd2);
    check_eq("setup_busy", 32'(busy_o), 32'd1);
    tick();
    check_eq("req_high_cycle2", 32'(xfer_req_o), 32'd1);
    check_eq("req_data", 32'(xfer_data_o), 32'hA5);
    drain(100);

    // All four from reset, then a second round of 0 and 3
    apply_reset();
    data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    req_i  = 4'b1111;
    push_service(req_i, 1'b0);
    drain(200);
    data_i = {8'hD3, 8'h77, 8'h66, 8'hD0};
    req_i  = 4'b1001;
    push_service(req_i, 1'b0);
    drain(200);

    // Ack never rises: timeout in the request phase
    ack_mode = 1;
    data_i[15:8] = 8'hE1;
    req_i = 4'b0010;
    push_service(req_i, 1'b1);
    drain(200);
    ack_mode = 0;

    // Ack stuck high after release: timeout in the release phase
    ack_mode = 2;
    data_i[23:16] = 8'hB7;
    req_i = 4'b0100;
    push_service(req_i, 1'b1);
    drain(200);
    check_eq("stuck_req_low", 32'(xfer_req_o), 32'd0);
    ack_mode = 0;
    for (int i = 0; i < 10 && xfer_ack_i; i++) tick();
    data_i[31:24] = 8'h9E;
    req_i = 4'b1000;
    push_service(req_i, 1'b0);
    drain(100);

    // Reset in the middle of a request phase
    data_i[15:8] = 8'h2B;
    req_i = 4'b0010;
    push_service(req_i, 1'b0);
    drain(100);
    ack_mode = 1;
    data_i = {8'hC3, 8'h00, 8'h00, 8'hC0};
    req_i  = 4'b1001;
    for (int i = 0; i < 10 && !xfer_req_o; i++) tick();
    check_eq("pre_reset_req", 32'(xfer_req_o), 32'd1);
    check_eq("pre_reset_gnt", 32'(gnt_id_o), 32'd3);
    for (int i = 0; i < 5; i++) tick();
    reset_n = 1'b0;
    #2;
    check_reset_outputs("mid_reset");
    sb.delete();
    model_ptr  = 0;
    ack_mode   = 0;
    xfer_ack_i = 1'b0;
    hi_cnt     = 0;
    lo_cnt     = 0;
    tick();
    reset_n = 1'b1;
    push_service(req_i, 1'b0);
    drain(200);

    // Requester drops its request mid-transfer; payload input also changes
    data_i[15:8] = 8'h6D;
    req_i = 4'b0010;
    push_service(req_i, 1'b0);
    tick();
    tick();
    req_i = 4'b0000;
    data_i[15:8] = 8'h00;
    for (int i = 0; i < 30 && (busy_o || sb.size() != 0); i++) begin
      tick();
      if (busy_o && xfer_data_o !== 8'h6D) hold_bad++;
    end
    check_eq("data_hold", 32'(hold_bad), 32'd0);
    drain(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
